// File: rtl/uni_axi_bridge_if.sv
// uni_if: single-request memory port between the load/store unit (master)
// and a responder. ready pulses for one cycle per request, with rdata valid in that cycle.
`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif

interface uni_if;
  logic                   valid;
  logic                   reqtyp;  // 1 = write
  logic [`CPU_WIDTH-1:0]  addr;
  logic [`CPU_WIDTH-1:0]  wdata;
  logic [1:0]             size;    // 2^size bytes
  logic                   ready;
  logic [`CPU_WIDTH-1:0]  rdata;

  modport Slave  (input  valid, reqtyp, addr, wdata, size, output ready, rdata);
  modport Master (output valid, reqtyp, addr, wdata, size, input  ready, rdata);
endinterface

// File: rtl/uni_axi_bridge.sv
// Converts one uni_if request at a time into a single-beat AXI4 transaction
// and returns completion as a one-cycle ready pulse with right-aligned read data.
module uni_axi_bridge #(
  parameter int AXI_IDW = 4,
  parameter int AXI_ID  = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  uni_if.Slave                  UniIf_S,
  output logic                  o_axi_awvalid,
  input  logic                  i_axi_awready,
  output logic [`CPU_WIDTH-1:0] o_axi_awaddr,
  output logic [2:0]            o_axi_awsize,
  output logic [AXI_IDW-1:0]    o_axi_awid,
  output logic                  o_axi_wvalid,
  input  logic                  i_axi_wready,
  output logic [`CPU_WIDTH-1:0] o_axi_wdata,
  output logic [7:0]            o_axi_wstrb,
  output logic                  o_axi_wlast,
  input  logic                  i_axi_bvalid,
  output logic                  o_axi_bready,
  input  logic [1:0]            i_axi_bresp,
  output logic                  o_axi_arvalid,
  input  logic                  i_axi_arready,
  output logic [`CPU_WIDTH-1:0] o_axi_araddr,
  output logic [2:0]            o_axi_arsize,
  output logic [AXI_IDW-1:0]    o_axi_arid,
  input  logic                  i_axi_rvalid,
  output logic                  o_axi_rready,
  input  logic [`CPU_WIDTH-1:0] i_axi_rdata,
  input  logic [1:0]            i_axi_rresp,
  output logic                  o_bus_err
);

  localparam int W = `CPU_WIDTH;
  localparam logic [AXI_IDW-1:0] ID = AXI_IDW'(AXI_ID);

  typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, RESP} state_t;

  state_t         state, state_n;
  logic           aw_done, w_done, aw_done_n, w_done_n;
  logic           awvalid_q, wvalid_q, arvalid_q, rready_q, bready_q, ready_q;
  logic [W-1:0]   addr_q, wdata_q, rdata_q;
  logic [1:0]     size_q;
  logic [7:0]     wstrb_q;
  logic           err_q;
  logic           take, misaligned;
  logic [2:0]     align_mask;

  function automatic logic [7:0] size_strb(input logic [1:0] s);
    case (s)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [W-1:0] lane_mask(input logic [7:0] strb);
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < W/8; i++) m[i*8 +: 8] = {8{strb[i]}};
    return m;
  endfunction

  assign take       = (state == IDLE) && UniIf_S.valid;
  assign align_mask = 3'((4'd1 << UniIf_S.size) - 4'd1);
  assign misaligned = |(UniIf_S.addr[2:0] & align_mask);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_n   = state;
    aw_done_n = aw_done;
    w_done_n  = w_done;
    unique case (state)
      IDLE: begin
        if (take) begin
          if (misaligned) begin
            state_n = RESP;
          end else if (UniIf_S.reqtyp) begin
            state_n   = AW_W;
            aw_done_n = 1'b0;
            w_done_n  = 1'b0;
          end else begin
            state_n = AR;
          end
        end
      end
      AR:   if (arvalid_q && i_axi_arready) state_n = R;
      R:    if (i_axi_rvalid) state_n = RESP;
      AW_W: begin
        if (awvalid_q && i_axi_awready) aw_done_n = 1'b1;
        if (wvalid_q && i_axi_wready)   w_done_n  = 1'b1;
        // Both channels may complete in the same cycle.
        if (aw_done_n && w_done_n) state_n = B;
      end
      B:    if (i_axi_bvalid) state_n = RESP;
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      bready_q  <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state     <= state_n;
      aw_done   <= aw_done_n;
      w_done    <= w_done_n;
      awvalid_q <= (state_n == AW_W) && !aw_done_n;
      wvalid_q  <= (state_n == AW_W) && !w_done_n;
      arvalid_q <= (state_n == AR);
      rready_q  <= (state_n == R);
      bready_q  <= (state_n == B);
      ready_q   <= (state_n == RESP);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (take) begin
        addr_q  <= UniIf_S.addr;
        size_q  <= UniIf_S.size;
        wdata_q <= UniIf_S.wdata << {UniIf_S.addr[2:0], 3'b000};
        wstrb_q <= size_strb(UniIf_S.size) << UniIf_S.addr[2:0];
        rdata_q <= '0;
        if (misaligned) err_q <= 1'b1;
      end
      if (state == R && i_axi_rvalid) begin
        rdata_q <= (i_axi_rdata >> {addr_q[2:0], 3'b000}) & lane_mask(size_strb(size_q));
        if (i_axi_rresp != 2'b00) err_q <= 1'b1;
      end
      if (state == B && i_axi_bvalid && i_axi_bresp != 2'b00) err_q <= 1'b1;
    end
  end

  assign UniIf_S.ready  = ready_q;
  assign UniIf_S.rdata  = rdata_q;
  assign o_axi_awvalid  = awvalid_q;
  assign o_axi_awaddr   = addr_q;
  assign o_axi_awsize   = {1'b0, size_q};
  assign o_axi_awid     = ID;
  assign o_axi_wvalid   = wvalid_q;
  assign o_axi_wdata    = wdata_q;
  assign o_axi_wstrb    = wstrb_q;
  assign o_axi_wlast    = 1'b1;
  assign o_axi_bready   = bready_q;
  assign o_axi_arvalid  = arvalid_q;
  assign o_axi_araddr   = addr_q;
  assign o_axi_arsize   = {1'b0, size_q};
  assign o_axi_arid     = ID;
  assign o_axi_rready   = rready_q;
  assign o_bus_err      = err_q;

endmodule
